// File: rtl/instr_dispatch_queue.sv
// In-order instruction queue with opcode decode and valid/ready dispatch to NUM_CH channels.
// Optional perf counters enabled by INSTR_DISPATCH_PERF_EN; ports exist (tied 0) when undefined.
module instr_dispatch_queue #(
  parameter int unsigned INSTR_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned REFILL_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [INSTR_WIDTH-1:0]        in_instr,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          fetch_req,
  output logic [INSTR_WIDTH-1:0]        ch_instr,
  output logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH-1:0]             ch_ready,
  input  logic [NUM_CH-1:0]             ch_done,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          err_opcode,
  output logic [31:0]                   perf_disp_cnt,
  output logic [31:0]                   perf_stall_cnt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_DISP = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic [2:0]             state_q, state_d;
  logic [NUM_CH-1:0]      ch_valid_q, ch_valid_d, tgt_q, tgt_d;
  logic [INSTR_WIDTH-1:0] ch_instr_q, ch_instr_d;
  logic [NUM_CH-1:0]      ch_busy_q, ch_busy_d, hs;
  logic                   err_q, err_d, busy_q, busy_d;
  logic                   fetch_q, fetch_d, armed_q, armed_d;
  logic                   push, pop, empty;
  logic [INSTR_WIDTH-1:0] head;
  logic [3:0]             head_opc;
  logic [NUM_CH-1:0]      head_oh;

  assign push     = in_valid && in_ready_q;
  assign empty    = (count_q == '0);
  assign head     = mem[rd_ptr_q];
  assign head_opc = head[INSTR_WIDTH-1 -: 4];
  assign head_oh  = NUM_CH'(1) << (head_opc - 4'd1);
  assign hs       = ch_valid_q & ch_ready;
  // A new handshake wins over a same-cycle done so the channel stays busy.
  assign ch_busy_d = hs | (ch_busy_q & ~ch_done);

  // Dispatch FSM; every pop (from RUN or back-to-back from DISP) shares one decode.
  always_comb begin
    state_d    = state_q;
    ch_valid_d = ch_valid_q;
    ch_instr_d = ch_instr_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable) state_d = S_IDLE;
        else if (!empty) pop = 1'b1;
      end
      S_DISP: begin
        if (|hs) begin
          ch_valid_d = '0;
          if (!enable) state_d = S_IDLE;
          else if (!empty) pop = 1'b1;
          else state_d = S_RUN;
        end else begin
          ch_valid_d = tgt_q & ~ch_busy_d;
        end
      end
      S_SYNC: if (ch_busy_d == '0) state_d = S_RUN;
      S_HALT: if (ch_busy_d == '0 && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_RUN;
      if (head_opc == 4'hE) begin
        state_d = S_HALT;
      end else if (head_opc == 4'hF) begin
        state_d = S_SYNC;
      end else if (head_opc != 4'h0 && head_opc <= 4'(NUM_CH)) begin
        state_d    = S_DISP;
        tgt_d      = head_oh;
        ch_instr_d = head;
        ch_valid_d = head_oh & ~ch_busy_d;
      end else if (head_opc != 4'h0) begin
        err_d = 1'b1;
      end
    end
  end

  // Queue pointers, occupancy, refill watermark and status.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != LW'(FIFO_DEPTH));
    armed_d    = armed_q;
    fetch_d    = 1'b0;
    if (count_d > LW'(REFILL_LEVEL)) begin
      armed_d = 1'b1;
    end else if (armed_q && (state_d == S_RUN || state_d == S_DISP)) begin
      fetch_d = 1'b1;
      armed_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE && state_d != S_HALT) || (|ch_busy_d);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      state_q    <= S_IDLE;
      ch_valid_q <= '0;
      tgt_q      <= '0;
      ch_instr_q <= '0;
      ch_busy_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      fetch_q    <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      state_q    <= state_d;
      ch_valid_q <= ch_valid_d;
      tgt_q      <= tgt_d;
      ch_instr_q <= ch_instr_d;
      ch_busy_q  <= ch_busy_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      fetch_q    <= fetch_d;
      armed_q    <= armed_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign fetch_req  = fetch_q;
  assign ch_instr   = ch_instr_q;
  assign ch_valid   = ch_valid_q;
  assign level      = count_q;
  assign busy       = busy_q;
  assign err_opcode = err_q;

`ifdef INSTR_DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d, perf_stall_q, perf_stall_d;
  logic        stall;

  // Stall: offered but refused, or head parked on a busy channel.
  always_comb begin
    stall        = (|(ch_valid_q & ~ch_ready)) || (state_q == S_DISP && ch_valid_q == '0);
    perf_disp_d  = ((|hs) && perf_disp_q != 32'hFFFF_FFFF) ? perf_disp_q + 32'd1 : perf_disp_q;
    perf_stall_d = (stall && perf_stall_q != 32'hFFFF_FFFF) ? perf_stall_q + 32'd1 : perf_stall_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_disp_q  <= perf_disp_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_disp_cnt  = perf_disp_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_disp_cnt  = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
